// File: rtl/dac_tx_pkg.sv
// rtl/dac_tx_pkg.sv - shared constants and sample conversion for the DAC transmitter
package dac_tx_pkg;

  localparam int DAC_W   = 14;
  localparam int SAT_MAX = (1 << (DAC_W - 1)) - 1;
  localparam int SAT_MIN = -(1 << (DAC_W - 1));

  localparam logic [DAC_W-1:0] DAC_MIDSCALE = {1'b1, {(DAC_W - 1) {1'b0}}};

  typedef struct packed {
    logic [DAC_W-1:0] code;
    logic             clip;
  } sat_res_t;

  // Clip to the DAC's signed range, then flip the MSB to get offset binary.
  function automatic sat_res_t sat_offset(input logic signed [31:0] x);
    sat_res_t          r;
    logic signed [31:0] y;
    y      = x;
    r.clip = (y > SAT_MAX) || (y < SAT_MIN);
    if (y > SAT_MAX) begin
      y = SAT_MAX;
    end else if (y < SAT_MIN) begin
      y = SAT_MIN;
    end
    r.code = {~y[DAC_W-1], y[DAC_W-2:0]};
    return r;
  endfunction

endpackage

// File: rtl/dac_stream_tx_if.sv
// rtl/dac_stream_tx_if.sv - valid/ready sample stream into the DAC transmitter
interface dac_stream_tx_if #(
  parameter int IN_WIDTH = 15
);
  logic signed [IN_WIDTH-1:0] data;
  logic                       valid;
  logic                       ready;

  modport master(output data, output valid, input ready);
  modport slave(input data, input valid, output ready);
endinterface

// File: rtl/sync_fifo_fwft.sv
// rtl/sync_fifo_fwft.sv - first-word-fall-through synchronous FIFO with occupancy count
module sync_fifo_fwft #(
  parameter int WIDTH = 15,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push;
  logic             pop;

  assign full    = (count == (AW + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign level   = count;
  assign rd_data = mem[rd_ptr];
  assign push    = wr_en && !full;
  assign pop     = rd_en && !empty;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dac_stream_tx.sv
// rtl/dac_stream_tx.sv - buffered, rate-divided sample output to a parallel offset-binary DAC
module dac_stream_tx
  import dac_tx_pkg::*;
#(
  parameter int IN_WIDTH         = 15,
  parameter int DAC_WIDTH        = DAC_W,
  parameter int DIV              = 5,
  parameter int FIFO_DEPTH       = 8,
  parameter bit HOLD_ON_UNDERRUN = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  dac_stream_tx_if.slave                s,
  input  logic                          enable,
  output logic [DAC_WIDTH-1:0]          dac_data,
  output logic                          dac_clk,
  output logic                          underrun,
  output logic                          sat,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int PW = $clog2(DIV);

  logic [PW-1:0]       phase;
  logic [IN_WIDTH-1:0] rd_data;
  logic                fifo_full;
  logic                fifo_empty;
  logic                push;
  logic                pop;
  logic                tick;
  logic [DAC_WIDTH-1:0] last_code;
  sat_res_t            conv;

  assign s.ready = rst_n && !fifo_full;
  assign push    = s.valid && s.ready;
  assign tick    = enable && (phase == '0);
  assign pop     = tick && !fifo_empty;

  always_comb begin
    conv = sat_offset(32'(signed'(rd_data)));
  end

  sync_fifo_fwft #(
    .WIDTH(IN_WIDTH),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_en  (push),
    .wr_data(s.data),
    .rd_en  (pop),
    .rd_data(rd_data),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .level  (fifo_level)
  );

  // dac_clk follows the pre-edge phase, so it rises DIV/2 cycles after the data update.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase     <= '0;
      dac_data  <= DAC_MIDSCALE;
      last_code <= DAC_MIDSCALE;
      dac_clk   <= 1'b0;
      underrun  <= 1'b0;
      sat       <= 1'b0;
    end else begin
      underrun <= 1'b0;
      sat      <= 1'b0;
      dac_clk  <= enable && (phase >= PW'(DIV / 2));
      if (!enable) begin
        phase <= '0;
      end else if (phase == PW'(DIV - 1)) begin
        phase <= '0;
      end else begin
        phase <= phase + 1'b1;
      end
      if (pop) begin
        dac_data  <= conv.code;
        last_code <= conv.code;
        sat       <= conv.clip;
      end else if (tick) begin
        underrun <= 1'b1;
        dac_data <= HOLD_ON_UNDERRUN ? last_code : DAC_MIDSCALE;
      end
    end
  end

endmodule

// File: tb/tb_dac_stream_tx.sv
// tb/tb_dac_stream_tx.sv - randomized and directed bench against a queue-based output model
module tb_dac_stream_tx;

  localparam int IN_WIDTH  = 15;
  localparam int DAC_WIDTH = 14;
  localparam int DIV       = 5;
  localparam int DEPTH     = 8;
  localparam int MID       = 8192;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                       rst_n;
  logic                       enable;
  logic                       vin;
  logic signed [IN_WIDTH-1:0] din;

  dac_stream_tx_if #(.IN_WIDTH(IN_WIDTH)) s_h ();
  dac_stream_tx_if #(.IN_WIDTH(IN_WIDTH)) s_m ();

  assign s_h.data  = din;
  assign s_h.valid = vin;
  assign s_m.data  = din;
  assign s_m.valid = vin;

  logic [DAC_WIDTH-1:0] dac_data_h, dac_data_m;
  logic                 dac_clk_h, dac_clk_m;
  logic                 underrun_h, underrun_m;
  logic                 sat_h, sat_m;
  logic [3:0]           level_h, level_m;

  dac_stream_tx #(
    .IN_WIDTH(IN_WIDTH), .DAC_WIDTH(DAC_WIDTH), .DIV(DIV),
    .FIFO_DEPTH(DEPTH), .HOLD_ON_UNDERRUN(1'b1)
  ) u_hold (
    .clk(clk), .rst_n(rst_n), .s(s_h.slave), .enable(enable),
    .dac_data(dac_data_h), .dac_clk(dac_clk_h), .underrun(underrun_h),
    .sat(sat_h), .fifo_level(level_h)
  );

  dac_stream_tx #(
    .IN_WIDTH(IN_WIDTH), .DAC_WIDTH(DAC_WIDTH), .DIV(DIV),
    .FIFO_DEPTH(DEPTH), .HOLD_ON_UNDERRUN(1'b0)
  ) u_mid (
    .clk(clk), .rst_n(rst_n), .s(s_m.slave), .enable(enable),
    .dac_data(dac_data_m), .dac_clk(dac_clk_m), .underrun(underrun_m),
    .sat(sat_m), .fifo_level(level_m)
  );

  int q[$];
  int ph;
  int last;
  int exp_h, exp_m;
  bit exp_clk, exp_ur, exp_sat;
  bit accepted;
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  function automatic int conv(input int v);
    if (v > 8191) return 16383;
    if (v < -8192) return 0;
    return v + 8192;
  endfunction

  task automatic step();
    bit push, tick;
    int v;
    push = vin && rst_n && (q.size() < DEPTH);
    tick = enable && (ph == 0);
    @(posedge clk);
    if (!rst_n) begin
      q.delete();
      ph = 0; last = MID; exp_h = MID; exp_m = MID;
      exp_clk = 0; exp_ur = 0; exp_sat = 0;
    end else begin
      exp_ur = 0; exp_sat = 0;
      if (tick) begin
        if (q.size() > 0) begin
          v = q.pop_front();
          exp_h = conv(v); exp_m = exp_h; last = exp_h;
          exp_sat = (v > 8191) || (v < -8192);
        end else begin
          exp_ur = 1; exp_h = last; exp_m = MID;
        end
      end
      if (push) q.push_back(int'(din));
      exp_clk = enable && (ph >= DIV / 2);
      ph = enable ? (ph + 1) % DIV : 0;
    end
    accepted = push;
    #1;
    check("dac_data_hold", int'(dac_data_h), exp_h);
    check("dac_data_mid", int'(dac_data_m), exp_m);
    check("dac_clk", int'(dac_clk_h), int'(exp_clk));
    check("dac_clk_mid", int'(dac_clk_m), int'(exp_clk));
    check("underrun", int'(underrun_h), int'(exp_ur));
    check("underrun_mid", int'(underrun_m), int'(exp_ur));
    check("sat", int'(sat_h), int'(exp_sat));
    check("sat_mid", int'(sat_m), int'(exp_sat));
    check("fifo_level", int'(level_h), q.size());
    check("fifo_level_mid", int'(level_m), q.size());
    check("s_ready", int'(s_h.ready), int'(rst_n && (q.size() < DEPTH)));
    check("s_ready_mid", int'(s_m.ready), int'(rst_n && (q.size() < DEPTH)));
  endtask

  task automatic push_one(input int d);
    vin = 1'b1;
    din = IN_WIDTH'(d);
    for (int k = 0; k < 60; k++) begin
      step();
      if (accepted) return;
    end
    check("push_timeout", 0, 1);
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; vin = 1'b0; din = '0;
    ph = 0; last = MID; exp_h = MID; exp_m = MID;
    exp_clk = 0; exp_ur = 0; exp_sat = 0; accepted = 0;

    repeat (3) step();
    rst_n = 1'b1;
    step();

    enable = 1'b1;
    push_one(0); push_one(-1); push_one(8191); push_one(-8192);
    vin = 1'b0;
    repeat (25) step();

    push_one(9000); push_one(-9000);
    vin = 1'b0;
    repeat (15) step();

    enable = 1'b0;
    for (int i = 0; i < 8; i++) push_one(i * 100 - 300);
    din = IN_WIDTH'(900);
    repeat (5) step();
    check("bp_level_full", int'(level_h), 8);
    check("bp_ready_low", int'(s_h.ready), 0);
    enable = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      if (accepted) break;
    end
    check("bp_ninth_accepted", int'(accepted), 1);
    vin = 1'b0;
    repeat (60) step();

    push_one(100);
    vin = 1'b0;
    repeat (30) step();
    check("hold_last", int'(dac_data_h), 16'h2064);

    enable = 1'b0;
    for (int i = 0; i < 5; i++) push_one(1000 + i);
    vin = 1'b0;
    rst_n = 1'b0;
    step();
    check("midrst_level", int'(level_h), 0);
    rst_n = 1'b1; enable = 1'b1;
    repeat (30) step();

    for (int seg = 0; seg < 9; seg++) begin
      int pct;
      pct = (seg % 3 == 0) ? 10 : ((seg % 3 == 1) ? 30 : 90);
      for (int c = 0; c < 300; c++) begin
        if (accepted || !vin) begin
          vin = ($urandom_range(0, 99) < pct);
          din = IN_WIDTH'($urandom_range(0, 32767));
        end
        rst_n  = ($urandom_range(0, 399) != 0);
        enable = ($urandom_range(0, 24) != 0);
        step();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dac_stream_tx.md
Name: dac_stream_tx

Overview:
DAC-side transmitter and the output counterpart of the ADC capture path. It accepts signed samples from the LMS error output over a valid/ready stream and buffers them in a small FIFO. At a fixed divided sample rate it saturates each sample to DAC width, converts it to offset binary, and drives the parallel DAC bus plus a DAC clock. The DAC clock's rising edge falls mid-sample, so the external converter sees stable data.

Parameters:
IN_WIDTH, 15, width of signed input sample (DATAOUT_WIDTH+1)
DAC_WIDTH, 14, DAC bus width, offset-binary output
DIV, 5, clk cycles per DAC sample; legal range >= 2
FIFO_DEPTH, 8, input buffer entries; power of 2, >= 2
HOLD_ON_UNDERRUN, 1, 1 = repeat last code on underrun; 0 = output midscale

Ports:
clk  in  1  single clock for all logic
rst_n  in  1  synchronous, active-low reset
s_data  in  IN_WIDTH  signed two's-complement sample
s_valid  in  1  s_data is valid
s_ready  out  1  FIFO can accept a sample
enable  in  1  run sample timing; low = freeze output
dac_data  out  DAC_WIDTH  offset-binary DAC code (registered)
dac_clk  out  1  DAC latch clock (registered)
underrun  out  1  one-cycle pulse: tick occurred with FIFO empty
sat  out  1  one-cycle pulse: popped sample was clipped
fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - phase counter = 0; FIFO emptied; dac_data = midscale (1<<(DAC_WIDTH-1), i.e. 0x2000).
  - dac_clk = 0; underrun = 0; sat = 0; last-code register = midscale.
  - s_ready = 0 while rst_n=0; s_ready = 1 from the first cycle after release.
  - Reset mid-operation discards all buffered samples with no further output activity.
- Push handshake:
  - s_ready = !full, combinational from the occupancy count.
  - A sample is written when s_valid && s_ready.
  - When full, ready is low and the sample is held by the upstream.
- Phase counter:
  - While enable=1, phase counts 0..DIV-1 and wraps.
  - While enable=0, phase is forced to 0, dac_clk to 0, dac_data holds, and the FIFO still accepts pushes.
- Tick: a tick is a cycle with enable=1 and phase==0.
  - On a tick with the FIFO non-empty: pop one sample; dac_data <= conv(sample) at that edge; last <= conv(sample).
  - On a tick with the FIFO empty: underrun pulses for 1 cycle; dac_data <= last if HOLD_ON_UNDERRUN=1, else midscale.
- Push and pop in the same cycle: both happen and the level is unchanged.
- Push into an empty FIFO on a tick cycle: the pop sees empty, so that tick is an underrun; the sample is output at the next tick.
- Latency: a sample pushed at edge N into an empty FIFO reaches dac_data at the first tick edge >= N+1.
- dac_clk: registered. dac_clk = 1 when phase >= DIV/2 (integer division), else 0.
  - This gives >= DIV/2 clk cycles of setup before the rising edge and >= 1 cycle of hold after it.
- conv(x):
  - Saturate signed IN_WIDTH to [-(2^(DAC_WIDTH-1)), 2^(DAC_WIDTH-1)-1], i.e. [-8192, 8191].
  - Then invert the MSB (equivalent to adding 8192 modulo 2^14).
  - sat pulses in the pop cycle when clipping occurred.
- If IN_WIDTH <= DAC_WIDTH, the input is sign-extended and sat never asserts.
- FIFO pointers wrap modulo FIFO_DEPTH; occupancy saturates at neither end because the handshake prevents overflow and pop is gated by empty.

Decomposition:
- Package dac_tx_pkg:
  - constant DAC_MIDSCALE;
  - localparams for saturation limits derived from DAC_WIDTH;
  - function sat_offset(x) returning code and clip flag.
- One sub-module, sync_fifo_fwft: parameterised width/depth with wr_en, rd_en, full, empty and level.
- The top holds the phase counter, conversion, output registers and flags.

Test Plan:
- Reset: hold rst_n=0 3 cycles, release -> dac_data=0x2000, dac_clk=0, s_ready=0 during reset, s_ready=1 on the first cycle after.
- Conversion, DIV=5, enable=1: push 0, -1, 8191, -8192 back-to-back -> successive ticks give dac_data 0x2000, 0x1FFF, 0x3FFF, 0x0000; sat stays 0; dac_clk high on phases 2-4.
- Saturation: push 9000 then -9000 -> dac_data 0x3FFF then 0x0000, with one sat pulse for each pop.
- Backpressure: enable=0, push 9 samples with s_valid held -> s_ready drops after 8 and fifo_level=8. Raise enable -> ready returns 1 cycle after the first pop and the 9th sample is accepted.
- Underrun: push a single 100, then idle -> dac_data=0x2064 and an underrun pulse on each later tick; dac_data stays 0x2064 (HOLD=1) or returns to 0x2000 (HOLD=0).
- Mid-run reset: assert rst_n=0 with 5 queued samples -> fifo_level=0 and dac_data=0x2000 on the next edge; none of the old samples appear after release.
